// File: rtl/rom_loader.sv
// rom_loader: UART-fed program loader that assembles framed little-endian words and writes them into the instruction ROM
module rom_loader #(
  parameter int BAUD_DIV  = 434,
  parameter int ROM_DEPTH = 4096,
  parameter int TIMEOUT   = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        uart_rx_i,
  output logic        rom_we_o,
  output logic [31:0] rom_waddr_o,
  output logic [31:0] rom_wdata_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o
);
  localparam int CW = $clog2(BAUD_DIV);
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_t;
  typedef enum logic [2:0] {IDLE, LEN0, LEN1, DATA, CSUM} st_t;
  rx_t         rx_state, rx_state_n;
  st_t         state, state_n;
  logic        rx_s1, rx_s, rx_prev;
  logic [CW-1:0] cnt;
  logic [2:0]  bit_cnt;
  logic [7:0]  sh;
  logic        byte_rdy, ferr;
  logic [31:0] tmo;
  logic [15:0] n, idx, n_new;
  logic [7:0]  csum;
  logic [1:0]  k;
  logic [31:0] word;
  logic        tick, tick_half, start_edge, stop_tick, tmo_hit, too_big;
  logic        hdr, dat, wr, ok, bad;
  assign tick       = cnt == CW'(BAUD_DIV - 1);
  assign tick_half  = cnt == CW'(BAUD_DIV / 2 - 1);
  assign start_edge = rx_state == RX_IDLE && rx_prev && !rx_s;
  assign stop_tick  = rx_state == RX_STOP && tick;
  assign n_new      = {sh, n[7:0]};
  assign too_big    = {16'd0, n_new} > 32'(ROM_DEPTH);
  assign tmo_hit    = TIMEOUT != 0 && state != IDLE && tmo >= 32'(TIMEOUT - 1);
  assign hdr        = byte_rdy && state == IDLE && sh == 8'hA5;
  assign dat        = byte_rdy && state == DATA;
  assign wr         = dat && k == 2'd3;
  assign ok         = byte_rdy && state == CSUM && sh == csum;
  assign bad        = byte_rdy ? ((state == LEN1 && too_big) || (state == CSUM && sh != csum)) : (ferr || tmo_hit);
  assign busy_o     = state != IDLE;
  // RX bit-level sequencing: start qualification, 8 data bits, stop bit
  always_comb begin
    rx_state_n = rx_state;
    case (rx_state)
      RX_IDLE:  rx_state_n = start_edge ? RX_START : RX_IDLE;
      RX_START: rx_state_n = tick_half ? (rx_s ? RX_IDLE : RX_DATA) : RX_START;
      RX_DATA:  rx_state_n = tick && bit_cnt == 3'd7 ? RX_STOP : RX_DATA;
      default:  rx_state_n = tick ? RX_IDLE : RX_STOP;
    endcase
  end
  // RX synchroniser, bit timing, byte shift register and inter-byte timeout counter
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rx_s1    <= 1'b1;
      rx_s     <= 1'b1;
      rx_prev  <= 1'b1;
      rx_state <= RX_IDLE;
      cnt      <= '0;
      bit_cnt  <= '0;
      sh       <= '0;
      byte_rdy <= 1'b0;
      ferr     <= 1'b0;
      tmo      <= '0;
    end else begin
      rx_s1    <= uart_rx_i;
      rx_s     <= rx_s1;
      rx_prev  <= rx_s;
      rx_state <= rx_state_n;
      cnt      <= (rx_state == RX_IDLE || rx_state_n != rx_state || tick) ? '0 : cnt + 1'b1;
      bit_cnt  <= rx_state != RX_DATA ? 3'd0 : bit_cnt + 3'(tick);
      if (rx_state == RX_DATA && tick) sh <= {rx_s, sh[7:1]};
      byte_rdy <= stop_tick && rx_s;
      ferr     <= stop_tick && !rx_s;
      tmo      <= start_edge ? '0 : tmo + 32'(tmo != '1);
    end
  // Frame state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  // Frame sequencing: header, length, data words, checksum; errors abort to IDLE
  always_comb begin
    state_n = state;
    if (byte_rdy)
      case (state)
        IDLE:    state_n = sh == 8'hA5 ? LEN0 : IDLE;
        LEN0:    state_n = LEN1;
        LEN1:    state_n = too_big ? IDLE : (n_new == 16'd0 ? CSUM : DATA);
        DATA:    state_n = wr && idx + 16'd1 == n ? CSUM : DATA;
        default: state_n = IDLE;
      endcase
    else if (ferr || tmo_hit)
      state_n = IDLE;
  end
  // Frame datapath: length capture, word assembly, checksum, ROM write and status flags
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      n           <= '0;
      idx         <= '0;
      csum        <= '0;
      k           <= '0;
      word        <= '0;
      rom_we_o    <= 1'b0;
      rom_waddr_o <= '0;
      rom_wdata_o <= '0;
      done_o      <= 1'b0;
      err_o       <= 1'b0;
    end else begin
      rom_we_o <= wr;
      done_o   <= ok;
      err_o    <= hdr ? 1'b0 : (bad | err_o);
      if (hdr) begin
        idx  <= '0;
        csum <= '0;
        k    <= '0;
      end
      if (byte_rdy && state == LEN0) n[7:0] <= sh;
      if (byte_rdy && state == LEN1) n[15:8] <= sh;
      if (dat) begin
        word[8*k +: 8] <= sh;
        csum           <= csum + sh;
        k              <= k + 2'd1;
      end
      if (wr) begin
        rom_waddr_o <= {14'd0, idx, 2'b00};
        rom_wdata_o <= {sh, word[23:0]};
        idx         <= idx + 16'd1;
      end
    end
endmodule

// File: doc/rom_loader.md
# rom_loader

UART-fed program loader that writes instruction words into the instruction ROM's write port. The fetch path only reads the ROM; this block is the writer side. It receives a framed byte stream on a serial line, assembles little-endian 32-bit words, and issues one ROM write per word. It holds the core while a load is in progress.

## Interface
- BAUD_DIV, 434: clocks per UART bit (50 MHz / 115200); must be ≥ 4.
- ROM_DEPTH, 4096: ROM capacity in 32-bit words; also the maximum accepted word count.
- TIMEOUT, 0: inter-byte timeout in clocks once a frame has started; 0 disables the timeout.
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-high reset.
- uart_rx_i  in  1  serial input, idle high, 8N1, LSB first.
- rom_we_o  out  1  ROM write strobe, one clk per word.
- rom_waddr_o  out  32  byte address of the write; always word aligned.
- rom_wdata_o  out  32  write data.
- busy_o  out  1  load in progress; the integrator maps it to the PC/IF hold.
- done_o  out  1  one-clk pulse on a successful load.
- err_o  out  1  sticky error flag, cleared when the next header is accepted.

## Operation
- uart_rx_i passes through a 2-FF synchroniser. Every check below uses the synchronised value.
- RX datapath:
  - A falling edge while idle starts a bit counter.
  - At BAUD_DIV/2 the line is re-sampled. If it is high, the start is treated as a glitch and the RX returns to idle.
  - Data bits are sampled every BAUD_DIV clocks after that, LSB first.
  - The stop bit is sampled at its mid-point.
  - Stop = 0 is a framing error: the byte is discarded, err_o is set, and the frame FSM returns to IDLE.
- Frame format: header 0xA5, then word count N (2 bytes, little-endian), then 4·N data bytes (little-endian words), then a checksum byte equal to the sum of all data bytes mod 256.
- Frame FSM states:
  - IDLE: a byte of 0xA5 → LEN0, set busy_o, clear err_o. Any other byte is ignored.
  - LEN0: store the byte as N[7:0] → LEN1.
  - LEN1: store the byte as N[15:8].
    - N > ROM_DEPTH → err_o, IDLE.
    - N = 0 → CSUM.
    - Otherwise → DATA.
  - DATA: shift each byte into bits [8k+7:8k], k = 0..3, and add it to the checksum accumulator.
    - After the 4th byte, issue the write and increment the word index.
    - When the index reaches N → CSUM.
  - CSUM: byte equal to the accumulator → pulse done_o. Otherwise set err_o. In both cases → IDLE.
- busy_o:
  - Goes high the clock after the header is accepted.
  - Goes low the same clock that the FSM enters IDLE.
- Write address: rom_waddr_o = word_index·4, where word_index is cleared on header acceptance.
- Writes that have already been issued are not rolled back on a later error.
- Timeout: with TIMEOUT ≠ 0 and the FSM not in IDLE, if TIMEOUT clocks pass with no start bit, set err_o and go to IDLE. The counter reloads on every detected start bit.
- Arithmetic widths:
  - Checksum accumulator: 8 bits, wraps.
  - Word count: 16 bits.
  - Word index: 16 bits, zero-extended and shifted by 2 to form the address.

## Timing
- Reset values: rom_we_o = 0, rom_waddr_o = 0, rom_wdata_o = 0, busy_o = 0, done_o = 0, err_o = 0. FSM = IDLE; RX = idle; word index, N and checksum = 0.
- Byte-ready strobe: one clk, registered, the cycle after the stop-bit sample.
- rom_we_o: high for exactly one clk, the cycle after the byte-ready strobe of the 4th byte. rom_waddr_o and rom_wdata_o are valid in that same cycle and hold their values until the next write.
- done_o / err_o: updated the cycle after the byte-ready strobe of the checksum byte.
- Frame errors are reported on the same timing relative to the stop-bit sample.
- Reset mid-byte or mid-frame: every output returns to its reset value asynchronously. A partially received word is never written.
- Back-to-back bytes with no idle time between the stop bit and the next start bit must be received correctly.
- The FSM can accept a new header in the cycle after done_o or err_o.

## Test plan
- Bench uses BAUD_DIV = 8.
- Load 2 words: send A5 02 00 13 05 10 00 93 05 20 00 plus checksum (0xE0, the sum of the 8 data bytes mod 256).
  - Expect rom_we_o pulse 1: waddr 0x0, wdata 0x00100513.
  - Expect rom_we_o pulse 2: waddr 0x4, wdata 0x00200593.
  - Expect a single done_o pulse, err_o = 0, and busy_o high from the cycle after the header until done_o.
- Bad checksum: the same frame with checksum 0x00 → both writes still occur, err_o = 1, no done_o, busy_o drops. A following correct frame clears err_o at its header.
- N = 0: A5 00 00 00 → no rom_we_o, done_o pulses. N = 0x1001 with ROM_DEPTH = 4096 → err_o after the LEN1 byte, no writes.
- Framing error: the second data byte is sent with stop bit = 0 → err_o, FSM back to IDLE, no write. A 0.5-bit low glitch on the idle line is ignored.
- Timeout (TIMEOUT = 200): send A5 02 00 13 and then stop → err_o rises 200 clks after the last start bit and busy_o falls.
- Reset: assert rst while the 3rd data byte is being received → every output is 0 on the next clock edge. A full frame sent afterwards loads from address 0.
